// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared segment type, blank pattern and active-low hex decode table
package sev_seg_pkg;
   typedef logic [6:0] seg_t;
   localparam seg_t SEG_OFF = 7'h7F;
   localparam seg_t SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
endpackage

// File: rtl/hex_to_sev_seg.sv
// hex_to_sev_seg: combinational nibble to active-low seven-segment pattern
module hex_to_sev_seg
   import sev_seg_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);
   assign seg = SEG_LUT[nib];
endmodule

// File: rtl/sev_seg_scan_mux.sv
// sev_seg_scan_mux: double-buffered, dead-timed, time-multiplexed N-digit hex display driver
module sev_seg_scan_mux
   import sev_seg_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic [N_DIGITS-1:0]   dp,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic                  lz_blank,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_done
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

   logic [PW-1:0]         pre_q, pre_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
   logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [N_DIGITS-1:0]   an_q, an_d, lz_mask;
   seg_t                  seg_q, seg_d, dec_seg;
   logic                  dp_n_q, dp_n_d, fd_q, fd_d;
   logic                  pre_wrap, frame_wrap, zero_run, sel_en, sel_lz, sel_dp, shown;
   logic [3:0]            nib;

   hex_to_sev_seg u_dec (.nib(nib), .seg(dec_seg));

   always_comb begin
      pre_wrap   = pre_q == PRE_LAST;
      frame_wrap = pre_wrap && idx_q == IDX_LAST;
      pre_d      = pre_wrap ? '0 : pre_q + PW'(1);
      idx_d      = frame_wrap ? '0 : pre_wrap ? idx_q + IW'(1) : idx_q;
      {pend_dig_d, pend_dp_d} = load ? {digits, dp} : {pend_dig_q, pend_dp_q};
      {act_dig_d, act_dp_d}   = frame_wrap ? {pend_dig_q, pend_dp_q} : {act_dig_q, act_dp_q};
      // lz_mask[i]: nibbles i..N-1 of the next active buffer are all zero
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run && act_dig_d[4*i +: 4] == 4'h0;
         lz_mask[i] = zero_run;
      end
      nib    = '0;
      sel_en = 1'b0;
      sel_lz = 1'b0;
      sel_dp = 1'b0;
      for (int i = 0; i < N_DIGITS; i++)
         if (idx_d == IW'(i)) begin
            nib    = act_dig_d[4*i +: 4];
            sel_en = digit_en[i];
            sel_lz = i != 0 && lz_mask[i];
            sel_dp = act_dp_d[i];
         end
      shown  = sel_en && !(lz_blank && sel_lz) && pre_d >= BLANK_END;
      an_d   = shown ? ~(N_DIGITS'(1) << idx_d) : '1;
      seg_d  = shown ? dec_seg : SEG_OFF;
      dp_n_d = !(shown && sel_dp);
      fd_d   = frame_wrap;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pre_q      <= '0;
         idx_q      <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         an_q       <= '1;
         seg_q      <= SEG_OFF;
         dp_n_q     <= 1'b1;
         fd_q       <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_n_q     <= dp_n_d;
         fd_q       <= fd_d;
      end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_sev_seg_scan_mux.sv
// tb_sev_seg_scan_mux: randomized scoreboard bench against a slot/frame-arithmetic display model
module tb_sev_seg_scan_mux;
   localparam int N = 4;
   localparam int R = 4;
   localparam int B = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   digits = '0;
   logic [3:0]    dp = '0;
   logic [3:0]    digit_en = 4'hF;
   logic          lz_blank = 1'b0;
   logic [6:0]    seg;
   logic          dp_n;
   logic [3:0]    an;
   logic          frame_done;

   logic [6:0]    lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [12:0]   exp_q [$];
   int            k = 0;
   logic [15:0]   pend_d = '0, act_d = '0;
   logic [3:0]    pend_p = '0, act_p = '0;
   int            n_cmp = 0, n_fail = 0;

   sev_seg_scan_mux #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp(dp),
      .digit_en(digit_en), .lz_blank(lz_blank), .seg(seg), .dp_n(dp_n),
      .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Expected {frame_done, dp_n, seg, an} after k edges since reset release
   function automatic logic [12:0] model_out();
      int   p = k % R;
      int   s = (k / R) % N;
      bit   upper_zero = 1'b1;
      bit   shown;
      for (int j = s; j < N; j++)
         if (act_d[4*j +: 4] != 4'h0) upper_zero = 1'b0;
      shown = p >= B && digit_en[s] && !(lz_blank && s > 0 && upper_zero);
      return {(k % (N * R) == 0) ? 1'b1 : 1'b0,
              shown ? ~act_p[s] : 1'b1,
              shown ? lut[act_d[4*s +: 4]] : 7'h7F,
              shown ? ~(4'b0001 << s) : 4'hF};
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         k = 0;
         pend_d = '0;
         act_d = '0;
         pend_p = '0;
         act_p = '0;
         exp_q.delete();
      end else begin
         k++;
         if (k % (N * R) == 0) begin
            act_d = pend_d;
            act_p = pend_p;
         end
         if (load) begin
            pend_d = digits;
            pend_p = dp;
         end
         exp_q.push_back(model_out());
      end
   end

   task automatic compare(input string name, input logic [12:0] e);
      n_cmp++;
      if ({frame_done, dp_n, seg, an} !== e) begin
         n_fail++;
         $display("FAIL %s t=%0t k=%0d: got an=%b seg=%h dp_n=%b fd=%b, want an=%b seg=%h dp_n=%b fd=%b",
                  name, $time, k, an, seg, dp_n, frame_done, e[3:0], e[10:4], e[11], e[12]);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst_n) compare("reset", {1'b0, 1'b1, 7'h7F, 4'hF});
      else if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard t=%0t: no expected entry", $time);
      end else compare("scan", exp_q.pop_front());
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      digits = d;
      dp = p;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // k counts edges already taken; inputs set now are sampled at edge k+1
   task automatic wait_k(input int m, input int v);
      int n = 0;
      while (k % m != v && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (k % m != v) begin
         n_fail++;
         $display("FAIL wait_k: phase %0d mod %0d not reached, at %0d", v, m, k % m);
      end
   endtask

   initial begin
      cycles(3);
      #1 rst_n = 1'b1;
      cycles(2 * N * R);
      wait_k(N * R, 5);
      do_load(16'h12AF, 4'h0);
      cycles(3 * N * R);
      lz_blank = 1'b1;
      do_load(16'h0050, 4'h0);
      cycles(2 * N * R + 3);
      do_load(16'h0000, 4'h0);
      cycles(2 * N * R);
      lz_blank = 1'b0;
      digit_en = 4'b1010;
      do_load(16'h3456, 4'b0011);
      cycles(2 * N * R);
      digit_en = 4'hF;
      wait_k(N * R, 2);
      do_load(16'h1111, 4'h0);
      wait_k(N * R, N * R - 1);
      do_load(16'h9999, 4'hF);
      cycles(3 * N * R);
      wait_k(N * R, 2 * R + 1);
      #2 rst_n = 1'b0;
      #1 compare("async_reset", {1'b0, 1'b1, 7'h7F, 4'hF});
      cycles(2);
      #1 rst_n = 1'b1;
      cycles(2 * N * R);
      for (int it = 0; it < 60; it++) begin
         lz_blank = 1'($urandom);
         digit_en = $urandom_range(3) == 0 ? 4'($urandom) : 4'hF;
         if ($urandom_range(1) == 1)
            do_load(16'($urandom >> (4 * $urandom_range(3))), 4'($urandom));
         cycles($urandom_range(12, 1));
      end
      cycles(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
